// File: rtl/min_os_peer.sv
// min_os_peer: host-side peer of the MinOS typed-chunk protocol.
// Decodes board chunks (leds, display, text) into mirror registers and
// encodes host events (buttons, switches, text) into outgoing chunks.
// Optional text support is enabled by defining MIN_OS_PEER_TEXT_EN.
module min_os_peer #(
  parameter int BUF_BYTE_SIZE       = 33,
  parameter int BUF_INDEX_SIZE      = 8,
  parameter int DISPLAY_BYTE_SIZE   = 64,
  parameter logic [7:0] T_LEDS      = 8'd2,
  parameter logic [7:0] T_BUTTONS   = 8'd3,
  parameter logic [7:0] T_SWITCHES  = 8'd4,
  parameter logic [7:0] T_TEXT      = 8'd5,
  parameter logic [7:0] T_DISPLAY   = 8'd6
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [7:0]                     rx_chunk_type,
  input  logic [BUF_BYTE_SIZE*8-1:0]     rx_chunk_bytes,
  input  logic [BUF_INDEX_SIZE-1:0]      rx_chunk_byte_size,
  input  logic                           rx_is_chunk_ready,
  output logic [7:0]                     tx_chunk_type,
  output logic [BUF_BYTE_SIZE*8-1:0]     tx_chunk_bytes,
  output logic [BUF_INDEX_SIZE-1:0]      tx_chunk_byte_size,
  output logic                           tx_is_chunk_ready,
  input  logic                           tx_chunker_done,
  input  logic [7:0]                     switches,
  input  logic                           button_event,
  input  logic [7:0]                     button_index,
  input  logic                           button_pressed,
  input  logic                           tx_text_send,
  input  logic [255:0]                   tx_text_bytes,
  input  logic [7:0]                     tx_text_size,
  output logic [7:0]                     leds,
  output logic [DISPLAY_BYTE_SIZE*8-1:0] display,
  output logic [255:0]                   rx_text_bytes,
  output logic [7:0]                     rx_text_size,
  output logic                           rx_text_valid,
  output logic                           bad_chunk
);

  localparam int PW         = BUF_BYTE_SIZE * 8;
  localparam int DISP_IDX_W = $clog2(DISPLAY_BYTE_SIZE);
  localparam logic [7:0] DISP_LIMIT = 8'(DISPLAY_BYTE_SIZE);
  localparam logic [7:0] TEXT_MAX   = 8'd32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BTN_LOAD,
    S_SW_LOAD,
    S_WAIT
`ifdef MIN_OS_PEER_TEXT_EN
    , S_TXT_LOAD
`endif
  } state_t;

  state_t state, state_next;

  // Keep bytes 0..len-1 of a text field, zero everything above.
  function automatic logic [255:0] mask_text(input logic [255:0] b, input logic [7:0] len);
    logic [255:0] r;
    for (int i = 0; i < 32; i++)
      r[i*8 +: 8] = (8'(i) < len) ? b[i*8 +: 8] : 8'h00;
    return r;
  endfunction

  // Clamp a requested text length to the 32-byte text field.
  function automatic logic [7:0] clamp_len(input logic [7:0] n);
    return (n > TEXT_MAX) ? TEXT_MAX : n;
  endfunction

  function automatic logic [PW-1:0] pack_btn(input logic [7:0] idx, input logic prs);
    logic [PW-1:0] r;
    r        = '0;
    r[7:0]   = idx;
    r[15:8]  = {7'd0, prs};
    return r;
  endfunction

  function automatic logic [PW-1:0] pack_sw(input logic [7:0] sw);
    logic [PW-1:0] r;
    r      = '0;
    r[7:0] = sw;
    return r;
  endfunction

  // ---------------- RX decode stage (p0 = combinational checks) ----------------
  logic [7:0]            rx_b0, rx_b1;
  logic [DISP_IDX_W-1:0] disp_idx_p0;
  logic                  leds_ok_p0, disp_ok_p0, text_ok_p0;

  assign rx_b0       = rx_chunk_bytes[7:0];
  assign rx_b1       = rx_chunk_bytes[15:8];
  assign disp_idx_p0 = rx_b0[DISP_IDX_W-1:0];

  // Classify the incoming chunk; anything not matching a legal shape is bad.
  always_comb begin
    leds_ok_p0 = (rx_chunk_type == T_LEDS) && (rx_chunk_byte_size == BUF_INDEX_SIZE'(1));
    disp_ok_p0 = (rx_chunk_type == T_DISPLAY) && (rx_chunk_byte_size == BUF_INDEX_SIZE'(2)) &&
                 (rx_b0 < DISP_LIMIT);
    text_ok_p0 = 1'b0;
`ifdef MIN_OS_PEER_TEXT_EN
    text_ok_p0 = (rx_chunk_type == T_TEXT) && (rx_b0 <= TEXT_MAX) &&
                 (rx_chunk_byte_size == BUF_INDEX_SIZE'(rx_b0) + BUF_INDEX_SIZE'(1));
`endif
  end

  // Mirror registers and one-cycle rx status strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      leds      <= '0;
      display   <= '0;
      bad_chunk <= 1'b0;
    end else begin
      bad_chunk <= 1'b0;
      if (rx_is_chunk_ready) begin
        if (leds_ok_p0)
          leds <= rx_b0;
        else if (disp_ok_p0)
          display[{disp_idx_p0, 3'b000} +: 8] <= rx_b1;
        else if (!text_ok_p0)
          bad_chunk <= 1'b1;
      end
    end
  end

`ifdef MIN_OS_PEER_TEXT_EN
  // Text mirror: payload bytes 1..len, zero-filled above the length.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_text_bytes <= '0;
      rx_text_size  <= '0;
      rx_text_valid <= 1'b0;
    end else begin
      rx_text_valid <= 1'b0;
      if (rx_is_chunk_ready && text_ok_p0) begin
        rx_text_bytes <= mask_text(rx_chunk_bytes[8 +: 256], rx_b0);
        rx_text_size  <= rx_b0;
        rx_text_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_text;
  assign unused_text   = ^{tx_text_send, tx_text_size, tx_text_bytes, rx_chunk_bytes[PW-1:16]};
  assign rx_text_bytes = '0;
  assign rx_text_size  = '0;
  assign rx_text_valid = 1'b0;
`endif

  // ---------------- Pending event capture ----------------
  logic         sw_pend, btn_pend, txt_pend;
  logic [7:0]   last_sent_switches, btn_idx, txt_size;
  logic         btn_prs;
  logic [255:0] txt_bytes;
  logic         load_btn, load_sw, load_txt;

  assign load_btn = (state == S_BTN_LOAD);
  assign load_sw  = (state == S_SW_LOAD);

  // Button and switch pending state; a fresh event beats the clearing load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_pend            <= 1'b0;
      last_sent_switches <= '0;
      btn_pend           <= 1'b0;
      btn_idx            <= '0;
      btn_prs            <= 1'b0;
    end else begin
      if (load_sw)
        last_sent_switches <= switches;
      sw_pend <= load_sw ? 1'b0 : (switches != last_sent_switches);
      if (button_event) begin
        btn_pend <= 1'b1;
        btn_idx  <= button_index;
        btn_prs  <= button_pressed;
      end else if (load_btn) begin
        btn_pend <= 1'b0;
      end
    end
  end

`ifdef MIN_OS_PEER_TEXT_EN
  assign load_txt = (state == S_TXT_LOAD);

  // Text pending state; length clamped and bytes above it zeroed at capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      txt_pend  <= 1'b0;
      txt_size  <= '0;
      txt_bytes <= '0;
    end else if (tx_text_send) begin
      txt_pend  <= 1'b1;
      txt_size  <= clamp_len(tx_text_size);
      txt_bytes <= mask_text(tx_text_bytes, clamp_len(tx_text_size));
    end else if (load_txt) begin
      txt_pend  <= 1'b0;
    end
  end
`else
  assign load_txt  = 1'b0;
  assign txt_pend  = 1'b0;
  assign txt_size  = '0;
  assign txt_bytes = '0;
`endif

  // ---------------- TX FSM ----------------
  logic [7:0]                hold_type;
  logic [PW-1:0]             hold_bytes;
  logic [BUF_INDEX_SIZE-1:0] hold_size;

  // State register; async reset drops any in-flight strobe at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state and chunk outputs; LOAD presents fresh data, otherwise the held chunk.
  always_comb begin
    state_next         = state;
    tx_is_chunk_ready  = 1'b0;
    tx_chunk_type      = hold_type;
    tx_chunk_bytes     = hold_bytes;
    tx_chunk_byte_size = hold_size;
    case (state)
      S_IDLE: begin
        if (btn_pend)      state_next = S_BTN_LOAD;
        else if (sw_pend)  state_next = S_SW_LOAD;
`ifdef MIN_OS_PEER_TEXT_EN
        else if (txt_pend) state_next = S_TXT_LOAD;
`endif
      end
      S_BTN_LOAD: begin
        tx_is_chunk_ready  = 1'b1;
        tx_chunk_type      = T_BUTTONS;
        tx_chunk_bytes     = pack_btn(btn_idx, btn_prs);
        tx_chunk_byte_size = BUF_INDEX_SIZE'(2);
        state_next         = S_WAIT;
      end
      S_SW_LOAD: begin
        tx_is_chunk_ready  = 1'b1;
        tx_chunk_type      = T_SWITCHES;
        tx_chunk_bytes     = pack_sw(switches);
        tx_chunk_byte_size = BUF_INDEX_SIZE'(1);
        state_next         = S_WAIT;
      end
`ifdef MIN_OS_PEER_TEXT_EN
      S_TXT_LOAD: begin
        tx_is_chunk_ready  = 1'b1;
        tx_chunk_type      = T_TEXT;
        tx_chunk_bytes     = '0;
        tx_chunk_bytes[7:0]     = txt_size;
        tx_chunk_bytes[8 +: 256] = txt_bytes;
        tx_chunk_byte_size = BUF_INDEX_SIZE'(txt_size + 8'd1);
        state_next         = S_WAIT;
      end
`endif
      S_WAIT: begin
        if (tx_chunker_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Hold the loaded chunk steady while the TX chunker works on it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_type  <= '0;
      hold_bytes <= '0;
      hold_size  <= '0;
    end else if (tx_is_chunk_ready) begin
      hold_type  <= tx_chunk_type;
      hold_bytes <= tx_chunk_bytes;
      hold_size  <= tx_chunk_byte_size;
    end
  end

endmodule
